// File: rtl/mpu_collector.sv
// mpu_collector: gathers the nine results from the 3x3 FMA cluster, acks each
// node as it is captured, then writes the buffered results to the matrix
// register file one element per cycle in row-major order.
module mpu_collector #(
  parameter int CLUSTER_DIM = 3,
  parameter int MBITS       = 1,
  parameter int NBITS       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              collect_start_in,
  output logic              collect_ack_out,
  output logic              collect_finished_out,
  input  logic              result_ready_0_0_in,
  input  logic              result_ready_0_1_in,
  input  logic              result_ready_0_2_in,
  input  logic              result_ready_1_0_in,
  input  logic              result_ready_1_1_in,
  input  logic              result_ready_1_2_in,
  input  logic              result_ready_2_0_in,
  input  logic              result_ready_2_1_in,
  input  logic              result_ready_2_2_in,
  input  logic [31:0]       result_data_0_0_in,
  input  logic [31:0]       result_data_0_1_in,
  input  logic [31:0]       result_data_0_2_in,
  input  logic [31:0]       result_data_1_0_in,
  input  logic [31:0]       result_data_1_1_in,
  input  logic [31:0]       result_data_1_2_in,
  input  logic [31:0]       result_data_2_0_in,
  input  logic [31:0]       result_data_2_1_in,
  input  logic [31:0]       result_data_2_2_in,
  output logic              result_ack_0_0_out,
  output logic              result_ack_0_1_out,
  output logic              result_ack_0_2_out,
  output logic              result_ack_1_0_out,
  output logic              result_ack_1_1_out,
  output logic              result_ack_1_2_out,
  output logic              result_ack_2_0_out,
  output logic              result_ack_2_1_out,
  output logic              result_ack_2_2_out,
  output logic              reg_collect_wr_en_out,
  output logic [MBITS:0]    reg_collect_i_out,
  output logic [NBITS:0]    reg_collect_j_out,
  output logic [31:0]       reg_collect_element_out
);

  localparam int NUM_NODES = CLUSTER_DIM * CLUSTER_DIM;

  localparam logic [1:0] COLL_IDLE   = 2'd0;
  localparam logic [1:0] COLL_GATHER = 2'd1;
  localparam logic [1:0] COLL_WRITE  = 2'd2;
  localparam logic [1:0] COLL_DONE   = 2'd3;

  logic [1:0]           r_state;
  logic [NUM_NODES-1:0] r_mask;
  logic [NUM_NODES-1:0] r_ack;
  logic [31:0]          r_buf [NUM_NODES];
  logic [3:0]           r_ptr;
  logic [1:0]           r_row;
  logic [1:0]           r_col;
  logic                 r_wr_en;
  logic [MBITS:0]       r_wi;
  logic [NBITS:0]       r_wj;
  logic [31:0]          r_el;
  logic                 r_fin;

  logic [NUM_NODES-1:0] w_ready;
  logic [31:0]          w_data [NUM_NODES];
  logic [NUM_NODES-1:0] w_cap;

  // Flatten node ports into slot index r*3+c.
  assign w_ready = {result_ready_2_2_in, result_ready_2_1_in, result_ready_2_0_in,
                    result_ready_1_2_in, result_ready_1_1_in, result_ready_1_0_in,
                    result_ready_0_2_in, result_ready_0_1_in, result_ready_0_0_in};
  assign w_data[0] = result_data_0_0_in;
  assign w_data[1] = result_data_0_1_in;
  assign w_data[2] = result_data_0_2_in;
  assign w_data[3] = result_data_1_0_in;
  assign w_data[4] = result_data_1_1_in;
  assign w_data[5] = result_data_1_2_in;
  assign w_data[6] = result_data_2_0_in;
  assign w_data[7] = result_data_2_1_in;
  assign w_data[8] = result_data_2_2_in;

  // A slot is captured only while gathering and only the first time it is ready.
  assign w_cap = (r_state == COLL_GATHER) ? (w_ready & ~r_mask) : '0;

  assign collect_ack_out         = (r_state != COLL_IDLE);
  assign collect_finished_out    = r_fin;
  assign reg_collect_wr_en_out   = r_wr_en;
  assign reg_collect_i_out       = r_wi;
  assign reg_collect_j_out       = r_wj;
  assign reg_collect_element_out = r_el;

  assign result_ack_0_0_out = r_ack[0];
  assign result_ack_0_1_out = r_ack[1];
  assign result_ack_0_2_out = r_ack[2];
  assign result_ack_1_0_out = r_ack[3];
  assign result_ack_1_1_out = r_ack[4];
  assign result_ack_1_2_out = r_ack[5];
  assign result_ack_2_0_out = r_ack[6];
  assign result_ack_2_1_out = r_ack[7];
  assign result_ack_2_2_out = r_ack[8];

  // Result holding buffer: a captured slot is written once per pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the buffer is reset explicitly so a discarded pass leaves no stale results behind.
      r_buf <= '{default: '0};
    end else begin
      for (int k = 0; k < NUM_NODES; k++) begin
        if (w_cap[k]) r_buf[k] <= w_data[k];
      end
    end
  end

  // Collection FSM, slot mask, acks and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLL_IDLE;
      r_mask  <= '0;
      r_ack   <= '0;
      r_ptr   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_wr_en <= 1'b0;
      r_wi    <= '0;
      r_wj    <= '0;
      r_el    <= '0;
      r_fin   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values; defaults below make pulses one cycle wide.
      r_ack   <= w_cap;
      r_wr_en <= 1'b0;
      r_wi    <= '0;
      r_wj    <= '0;
      r_el    <= '0;
      r_fin   <= 1'b0;
      case (r_state)
        COLL_IDLE: begin
          if (collect_start_in) begin
            r_state <= COLL_GATHER;
            r_mask  <= '0;
          end
        end
        COLL_GATHER: begin
          r_mask <= r_mask | w_cap;
          if ((r_mask | w_cap) == '1) begin
            r_state <= COLL_WRITE;
            r_ptr   <= '0;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        COLL_WRITE: begin
          r_wr_en <= 1'b1;
          r_wi    <= (MBITS+1)'(r_row);
          r_wj    <= (NBITS+1)'(r_col);
          r_el    <= r_buf[r_ptr];
          if (r_ptr == 4'd8) begin
            r_state <= COLL_DONE;
          end else begin
            r_ptr <= r_ptr + 4'd1;
            if (r_col == 2'd2) begin
              r_col <= 2'd0;
              r_row <= r_row + 2'd1;
            end else begin
              r_col <= r_col + 2'd1;
            end
          end
        end
        default: begin
          r_fin   <= 1'b1;
          r_state <= COLL_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_collector.sv
// Self-checking bench for mpu_collector: a reference buffer model builds the
// expected row-major write stream, which a monitor pops and compares.
module tb_mpu_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  rdy;
  logic [31:0] dat [9];
  logic        coll_ack, fin, wr_en;
  logic [1:0]  wi, wj;
  logic [31:0] wel;
  logic [8:0]  ack;

  typedef struct {
    logic [1:0]  i;
    logic [1:0]  j;
    logic [31:0] d;
  } wr_t;

  wr_t         q[$];
  logic [31:0] exp_buf [9];
  logic [8:0]  exp_mask;
  int          checks = 0;
  int          failures = 0;
  int          fin_cnt = 0;
  int          wr_cnt = 0;
  logic        prev_wr = 1'b0;
  logic        prev_fin = 1'b0;

  always #5 clk = ~clk;

  mpu_collector dut (
    .clk(clk), .rst_n(rst_n),
    .collect_start_in(start), .collect_ack_out(coll_ack), .collect_finished_out(fin),
    .result_ready_0_0_in(rdy[0]), .result_ready_0_1_in(rdy[1]), .result_ready_0_2_in(rdy[2]),
    .result_ready_1_0_in(rdy[3]), .result_ready_1_1_in(rdy[4]), .result_ready_1_2_in(rdy[5]),
    .result_ready_2_0_in(rdy[6]), .result_ready_2_1_in(rdy[7]), .result_ready_2_2_in(rdy[8]),
    .result_data_0_0_in(dat[0]), .result_data_0_1_in(dat[1]), .result_data_0_2_in(dat[2]),
    .result_data_1_0_in(dat[3]), .result_data_1_1_in(dat[4]), .result_data_1_2_in(dat[5]),
    .result_data_2_0_in(dat[6]), .result_data_2_1_in(dat[7]), .result_data_2_2_in(dat[8]),
    .result_ack_0_0_out(ack[0]), .result_ack_0_1_out(ack[1]), .result_ack_0_2_out(ack[2]),
    .result_ack_1_0_out(ack[3]), .result_ack_1_1_out(ack[4]), .result_ack_1_2_out(ack[5]),
    .result_ack_2_0_out(ack[6]), .result_ack_2_1_out(ack[7]), .result_ack_2_2_out(ack[8]),
    .reg_collect_wr_en_out(wr_en), .reg_collect_i_out(wi), .reg_collect_j_out(wj),
    .reg_collect_element_out(wel)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, expv, $time);
    end
  endtask

  // Monitor: pop expected writes, track finished pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wr_cnt++;
        if (q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          wr_t e;
          e = q.pop_front();
          check("wr_i", 64'(wi), 64'(e.i));
          check("wr_j", 64'(wj), 64'(e.j));
          check("wr_data", 64'(wel), 64'(e.d));
        end
      end
      if (fin) begin
        fin_cnt++;
        check("fin_after_last_write", 64'(prev_wr), 1);
        check("fin_single_cycle", 64'(prev_fin), 0);
        check("fin_queue_drained", 64'(q.size()), 0);
      end
      prev_wr  = wr_en;
      prev_fin = fin;
    end else begin
      prev_wr  = 1'b0;
      prev_fin = 1'b0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_pass();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    exp_mask = '0;
    check("coll_ack_in_gather", 64'(coll_ack), 1);
  endtask

  task automatic drive(input int k, input logic [31:0] d);
    rdy[k] = 1'b1;
    dat[k] = d;
    if (!exp_mask[k]) begin
      exp_buf[k]  = d;
      exp_mask[k] = 1'b1;
    end
  endtask

  task automatic step_acks(input string tag, input logic [8:0] expv);
    @(negedge clk);
    check(tag, 64'(ack), 64'(expv));
  endtask

  task automatic push_expected();
    for (int k = 0; k < 9; k++) begin
      wr_t e;
      e.i = 2'(k / 3);
      e.j = 2'(k % 3);
      e.d = exp_buf[k];
      q.push_back(e);
    end
  endtask

  task automatic wait_finish(input int max_cycles);
    int f0;
    f0 = fin_cnt;
    for (int n = 0; n < max_cycles; n++) begin
      step();
      if (fin_cnt != f0) break;
    end
    check("finish_seen", 64'(fin_cnt - f0), 1);
    check("queue_empty", 64'(q.size()), 0);
  endtask

  task automatic wait_writes(input int count, input int max_cycles);
    int w0;
    w0 = wr_cnt;
    for (int n = 0; n < max_cycles; n++) begin
      step();
      if (wr_cnt - w0 >= count) break;
    end
    check("writes_reached", 64'(wr_cnt - w0), 64'(count));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_acks"}, 64'(ack), 0);
    check({tag, "_wr_en"}, 64'(wr_en), 0);
    check({tag, "_fin"}, 64'(fin), 0);
    check({tag, "_idx"}, 64'({wi, wj}), 0);
    check({tag, "_el"}, 64'(wel), 0);
    check({tag, "_coll_ack"}, 64'(coll_ack), 0);
  endtask

  task automatic full_pass(input logic [31:0] base);
    start_pass();
    for (int k = 0; k < 9; k++) drive(k, base + 32'(k));
    step_acks("acks_all", 9'h1FF);
    rdy = '0;
    push_expected();
    wait_finish(30);
  endtask

  logic [31:0] fvals [9];
  int          f_before;

  initial begin
    fvals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
              32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
    rst_n = 1'b0;
    start = 1'b0;
    rdy   = '0;
    for (int k = 0; k < 9; k++) dat[k] = '0;
    exp_mask = '0;
    #1;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Reset mid-gather clears acks asynchronously and returns to idle.
    start_pass();
    for (int k = 0; k < 4; k++) drive(k, 32'h11110000 + 32'(k));
    step_acks("acks_partial", 9'h00F);
    rdy = '0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk) rst_n = 1'b1;
    step();
    check("idle_after_reset", 64'(coll_ack), 0);

    // All nine ready in a single cycle.
    start_pass();
    for (int k = 0; k < 9; k++) drive(k, fvals[k]);
    step_acks("acks_all_together", 9'h1FF);
    rdy = '0;
    push_expected();
    wait_finish(30);

    // One node per cycle in reverse order.
    start_pass();
    for (int k = 8; k >= 0; k--) begin
      drive(k, 32'hC0000000 + 32'(k));
      step_acks("ack_reverse", 9'(1 << k));
      rdy[k] = 1'b0;
    end
    push_expected();
    wait_finish(30);

    // Ready on (1,1) held past its ack with changing data.
    start_pass();
    drive(4, 32'h40400000);
    step_acks("ack_11_first", 9'h010);
    dat[4] = 32'h40800000;
    step_acks("ack_11_held_a", 9'h000);
    step_acks("ack_11_held_b", 9'h000);
    for (int k = 0; k < 9; k++) if (k != 4) drive(k, 32'h50000000 + 32'(k));
    step_acks("ack_rest", 9'h1EF);
    rdy = '0;
    push_expected();
    wait_finish(30);

    // Ready pulses while idle are ignored.
    rdy = '1;
    for (int n = 0; n < 3; n++) begin
      step();
      check("idle_no_ack", 64'(ack), 0);
      check("idle_no_write", 64'(wr_en), 0);
    end
    rdy = '0;

    // Start pulsed during the write phase is ignored.
    f_before = fin_cnt;
    start_pass();
    for (int k = 0; k < 9; k++) drive(k, 32'h3C000000 + 32'(k * 7));
    step_acks("acks_before_wstart", 9'h1FF);
    rdy = '0;
    push_expected();
    wait_writes(1, 10);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_finish(30);
    repeat (5) step();
    check("single_finish", 64'(fin_cnt - f_before), 1);
    check("no_restart", 64'(coll_ack), 0);

    // Reset at the 4th write cycle, then a clean pass.
    start_pass();
    for (int k = 0; k < 9; k++) drive(k, 32'h3E000000 + 32'(k));
    step_acks("acks_before_reset", 9'h1FF);
    rdy = '0;
    push_expected();
    wait_writes(4, 20);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("write_reset");
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      step();
      check("no_write_after_reset", 64'(wr_en), 0);
    end
    full_pass(32'h42000000);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mpu_collector.md
Name: mpu_collector

Overview:
Receive-side counterpart to the FMA cluster input path. Gathers the nine finished results from the 3x3 FMA cluster, acknowledges each node individually, buffers them, then writes them back into the matrix register file one element per cycle in row-major order. Signals completion to the MPU controller.

Parameters:
- CLUSTER_DIM, 3, FMA cluster rows and columns. Fixed at 3; the port list is sized for 3.
- NUM_NODES, CLUSTER_DIM*CLUSTER_DIM (9), number of result slots in the holding buffer.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset. Asynchronous, active-low.
- collect_start_in  input  1  begin a collection pass.
- collect_ack_out  output  1  high whenever state != COLL_IDLE.
- collect_finished_out  output  1  one-cycle pulse when all results have been written.
- result_ready_r_c_in (r,c in 0..2; 9 ports)  input  1 each  FMA node r,c has a valid result; held until acked.
- result_data_r_c_in (9 ports)  input  32 (float_sp) each  FMA node result.
- result_ack_r_c_out (9 ports)  output  1 each  one-cycle pulse; result captured.
- reg_collect_wr_en_out  output  1  register file write strobe.
- reg_collect_i_out  output  MBITS+1  write row index.
- reg_collect_j_out  output  NBITS+1  write column index.
- reg_collect_element_out  output  32 (float_sp)  write data.

Behaviour:
- Reset (async assert, rst_n=0):
  - state=COLL_IDLE; slot mask, write pointer and buffer cleared.
  - All outputs 0.
  - Any partial collection is discarded; no write occurs after reset asserts.
  - Deassertion is synchronised to clk by the surrounding reset logic.
- State COLL_IDLE:
  - Ready inputs ignored; no acks.
  - collect_start_in=1 -> COLL_GATHER next cycle; slot mask cleared.
- State COLL_GATHER:
  - Each cycle, every node with ready=1 and mask bit=0 is captured: buffer[r*3+c] <= data, mask bit set, result_ack_r_c_out=1 on the following cycle (registered, exactly one cycle).
  - Several nodes ready in the same cycle are all captured in that cycle.
  - Ready on an already-filled slot is ignored: no ack, buffer unchanged.
  - Once the mask is all ones (including the cycle of the final capture) -> COLL_WRITE next cycle.
- State COLL_WRITE:
  - Write pointer p counts 0..8, one write per cycle.
  - reg_collect_wr_en_out=1, i=p/3, j=p%3, element=buffer[p]. All write outputs are registered.
  - After p=8 -> COLL_DONE; wr_en=0 and indices/element return to 0.
  - First write is one cycle after entering COLL_WRITE.
  - Exactly 9 consecutive write cycles; no stalls (register file write port is always available).
- State COLL_DONE:
  - collect_finished_out=1 for one cycle -> COLL_IDLE.
- collect_start_in outside COLL_IDLE is ignored.
- collect_ack_out is combinational from state.
- No arithmetic on data; floats are passed bit-exact.

Test Plan:
1. Assert rst_n=0 mid-run, then release -> all acks, wr_en, finished and indices are 0 immediately (asynchronously); state is COLL_IDLE.
2. Start, then all 9 ready in one cycle with data 1.0..9.0 (0x3F800000..0x41100000, row-major) -> all 9 acks pulse together one cycle later; then 9 writes (0,0)=0x3F800000 … (2,2)=0x41100000; finished pulses one cycle after the last write.
3. Ready asserted one node per cycle in reverse order (2,2) down to (0,0), values 0xC0000000+k -> each ack arrives one cycle after its ready; writes still follow row-major order with the correct values.
4. Node (1,1) ready held with 0x40400000 and not dropped after the ack, then data changed to 0x40800000 -> no second ack; the write at (1,1) is 0x40400000.
5. Ready pulses on all nodes while in COLL_IDLE (no start) -> no acks, no writes. Then collect_start_in pulsed during COLL_WRITE -> ignored; only one finished pulse occurs.
6. rst_n=0 asserted at the 4th write cycle -> wr_en drops immediately. After release, a fresh start plus 9 results produces a full, correct 9-write pass.
